// File: rtl/mack_bus_master.sv
`default_nettype none
// ============================================================================
// mack_bus_master: single-word 68000 bus master (arbitrate, strobe, DTACK wait).
// Optional DTACK timeout with bus error: define MACK_BUS_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mack_bus_master #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        REQ_RW,
    input  logic [22:0] REQ_ADDR,
    input  logic        REQ_UDS,
    input  logic        REQ_LDS,
    input  logic [15:0] REQ_WDATA,
    output logic        ACK,
    output logic        ERR,
    output logic [15:0] RDATA,
    output logic        BUSY,
    output logic        BR_N,
    output logic        BGACK_N,
    input  logic        BG_N,
    input  logic        AS_IN_N,
    input  logic        DTACK_N,
    output logic        BUS_OE,
    output logic [22:0] ADDR,
    output logic        AS_N,
    output logic        UDS_N,
    output logic        LDS_N,
    output logic        RW,
    output logic [15:0] DATA_OUT,
    output logic        DATA_OE,
    input  logic [15:0] DATA_IN
);

    if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 4..255");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        S_ADDR    = 3'd2,
        S_STROBE  = 3'd3,
        S_WAIT    = 3'd4,
        S_LATCH   = 3'd5,
        S_RELEASE = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic        lat_rw_q, lat_rw_d;
    logic [22:0] lat_addr_q, lat_addr_d;
    logic        lat_uds_q, lat_uds_d;
    logic        lat_lds_q, lat_lds_d;
    logic [15:0] lat_wdata_q, lat_wdata_d;

    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        br_n_q, br_n_d;
    logic        bgack_n_q, bgack_n_d;
    logic        bus_oe_q, bus_oe_d;
    logic [22:0] addr_q, addr_d;
    logic        as_n_q, as_n_d;
    logic        uds_n_q, uds_n_d;
    logic        lds_n_q, lds_n_d;
    logic        rw_q, rw_d;
    logic [15:0] data_out_q, data_out_d;
    logic        data_oe_q, data_oe_d;
    logic [15:0] rdata_q, rdata_d;

    // Two-flop synchronizers; reset to the inactive (high) level
    logic        bg_meta_q, bg_sync_q;
    logic        asi_meta_q, asi_sync_q;
    logic        dt_meta_q, dt_sync_q;

`ifdef MACK_BUS_TIMEOUT_EN
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        tmo_q, tmo_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        lat_rw_d    = lat_rw_q;
        lat_addr_d  = lat_addr_q;
        lat_uds_d   = lat_uds_q;
        lat_lds_d   = lat_lds_q;
        lat_wdata_d = lat_wdata_q;
        ack_d       = 1'b0;
        br_n_d      = br_n_q;
        bgack_n_d   = bgack_n_q;
        bus_oe_d    = bus_oe_q;
        addr_d      = addr_q;
        as_n_d      = as_n_q;
        uds_n_d     = uds_n_q;
        lds_n_d     = lds_n_q;
        rw_d        = rw_q;
        data_out_d  = data_out_q;
        data_oe_d   = data_oe_q;
        rdata_d     = rdata_q;
`ifdef MACK_BUS_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_d       = tmo_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (REQ) begin
                    lat_rw_d    = REQ_RW;
                    lat_addr_d  = REQ_ADDR;
                    lat_uds_d   = REQ_UDS;
                    lat_lds_d   = REQ_LDS;
                    lat_wdata_d = REQ_WDATA;
                    br_n_d      = 1'b0;
                    state_d     = ARB;
                end
            end
            ARB: begin
                // Take the bus only once the current master has dropped AS
                if (!bg_sync_q && asi_sync_q) begin
                    bgack_n_d = 1'b0;
                    br_n_d    = 1'b1;
                    bus_oe_d  = 1'b1;
                    addr_d    = lat_addr_q;
                    rw_d      = lat_rw_q;
                    if (!lat_rw_q) begin
                        data_out_d = lat_wdata_q;
                        data_oe_d  = 1'b1;
                    end
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                as_n_d  = 1'b0;
                uds_n_d = !lat_uds_q;
                lds_n_d = !lat_lds_q;
                state_d = S_STROBE;
            end
            S_STROBE: begin
`ifdef MACK_BUS_TIMEOUT_EN
                tmo_cnt_d = 8'd0;
                tmo_d     = 1'b0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!dt_sync_q) begin
                    state_d = S_LATCH;
                end
`ifdef MACK_BUS_TIMEOUT_EN
                else if (tmo_cnt_q == c_timeout_last) begin
                    as_n_d  = 1'b1;
                    uds_n_d = 1'b1;
                    lds_n_d = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            S_LATCH: begin
                if (lat_rw_q) begin
                    rdata_d = DATA_IN;
                end
                as_n_d  = 1'b1;
                uds_n_d = 1'b1;
                lds_n_d = 1'b1;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
`ifdef MACK_BUS_TIMEOUT_EN
                if (dt_sync_q || tmo_q) begin
                    err_d = tmo_q;
`else
                if (dt_sync_q) begin
`endif
                    ack_d     = 1'b1;
                    bus_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    bgack_n_d = 1'b1;
                    rw_d      = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            lat_rw_q    <= 1'b1;
            lat_addr_q  <= 23'd0;
            lat_uds_q   <= 1'b0;
            lat_lds_q   <= 1'b0;
            lat_wdata_q <= 16'd0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            br_n_q      <= 1'b1;
            bgack_n_q   <= 1'b1;
            bus_oe_q    <= 1'b0;
            addr_q      <= 23'd0;
            as_n_q      <= 1'b1;
            uds_n_q     <= 1'b1;
            lds_n_q     <= 1'b1;
            rw_q        <= 1'b1;
            data_out_q  <= 16'd0;
            data_oe_q   <= 1'b0;
            rdata_q     <= 16'd0;
            bg_meta_q   <= 1'b1;
            bg_sync_q   <= 1'b1;
            asi_meta_q  <= 1'b1;
            asi_sync_q  <= 1'b1;
            dt_meta_q   <= 1'b1;
            dt_sync_q   <= 1'b1;
`ifdef MACK_BUS_TIMEOUT_EN
            tmo_cnt_q   <= 8'd0;
            tmo_q       <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lat_rw_q    <= lat_rw_d;
            lat_addr_q  <= lat_addr_d;
            lat_uds_q   <= lat_uds_d;
            lat_lds_q   <= lat_lds_d;
            lat_wdata_q <= lat_wdata_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            br_n_q      <= br_n_d;
            bgack_n_q   <= bgack_n_d;
            bus_oe_q    <= bus_oe_d;
            addr_q      <= addr_d;
            as_n_q      <= as_n_d;
            uds_n_q     <= uds_n_d;
            lds_n_q     <= lds_n_d;
            rw_q        <= rw_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            rdata_q     <= rdata_d;
            bg_meta_q   <= BG_N;
            bg_sync_q   <= bg_meta_q;
            asi_meta_q  <= AS_IN_N;
            asi_sync_q  <= asi_meta_q;
            dt_meta_q   <= DTACK_N;
            dt_sync_q   <= dt_meta_q;
`ifdef MACK_BUS_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign ACK      = ack_q;
    assign BUSY     = busy_q;
    assign BR_N     = br_n_q;
    assign BGACK_N  = bgack_n_q;
    assign BUS_OE   = bus_oe_q;
    assign ADDR     = addr_q;
    assign AS_N     = as_n_q;
    assign UDS_N    = uds_n_q;
    assign LDS_N    = lds_n_q;
    assign RW       = rw_q;
    assign DATA_OUT = data_out_q;
    assign DATA_OE  = data_oe_q;
    assign RDATA    = rdata_q;
`ifdef MACK_BUS_TIMEOUT_EN
    assign ERR      = err_q;
`else
    assign ERR      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mack_bus_master.sv
`default_nettype none
// ============================================================================
// tb_mack_bus_master: directed transactions against a transaction-level model
// with a per-cycle bus monitor. Revision: 1.0 - initial release
// ============================================================================
module tb_mack_bus_master;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ = 1'b0;
    logic        REQ_RW = 1'b1;
    logic [22:0] REQ_ADDR = '0;
    logic        REQ_UDS = 1'b0;
    logic        REQ_LDS = 1'b0;
    logic [15:0] REQ_WDATA = '0;
    logic        ACK, ERR, BUSY, BR_N, BGACK_N, BUS_OE;
    logic [15:0] RDATA, DATA_OUT;
    logic        BG_N = 1'b1;
    logic        AS_IN_N = 1'b1;
    logic        DTACK_N = 1'b1;
    logic [22:0] ADDR;
    logic        AS_N, UDS_N, LDS_N, RW, DATA_OE;
    logic [15:0] DATA_IN = 16'hDEAD;

    always #5 CLK = ~CLK;

    mack_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_ADDR(REQ_ADDR),
        .REQ_UDS(REQ_UDS), .REQ_LDS(REQ_LDS), .REQ_WDATA(REQ_WDATA),
        .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .BUSY(BUSY), .BR_N(BR_N),
        .BGACK_N(BGACK_N), .BG_N(BG_N), .AS_IN_N(AS_IN_N), .DTACK_N(DTACK_N),
        .BUS_OE(BUS_OE), .ADDR(ADDR), .AS_N(AS_N), .UDS_N(UDS_N), .LDS_N(LDS_N),
        .RW(RW), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the transfer in flight
    logic        m_rw = 1'b1, m_uds = 1'b0, m_lds = 1'b0, m_exp_err = 1'b0;
    logic [22:0] m_addr = '0;
    logic [15:0] m_wdata = '0, m_rdata = '0, m_rdata_next = '0;
    int          m_acks = 0, tx_count = 0, as_run = 0, last_as_len = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_for(input int which, input logic val, input int max, input string nm);
        logic s;
        for (int i = 0; i < max; i++) begin
            @(negedge CLK);
            case (which)
                0:       s = BR_N;
                1:       s = AS_N;
                2:       s = ACK;
                3:       s = BUS_OE;
                default: s = 1'bx;
            endcase
            if (s === val) begin
                checks++;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s timeout actual=not reached required=%0b within %0d cycles", nm, val, max);
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            if (!AS_N) begin
                chk("strobe_addr", 32'(ADDR), 32'(m_addr));
                chk("strobe_rw", 32'(RW), 32'(m_rw));
                chk("strobe_uds_n", 32'(UDS_N), 32'(!m_uds));
                chk("strobe_lds_n", 32'(LDS_N), 32'(!m_lds));
                chk("strobe_bus_oe", 32'(BUS_OE), 32'd1);
                chk("strobe_bgack_n", 32'(BGACK_N), 32'd0);
                chk("strobe_data_oe", 32'(DATA_OE), 32'(!m_rw));
                if (!m_rw) chk("strobe_data_out", 32'(DATA_OUT), 32'(m_wdata));
                as_run++;
            end else if (as_run != 0) begin
                last_as_len = as_run;
                as_run = 0;
            end
            chk("br_bgack_exclusive", 32'(!BR_N && !BGACK_N), 32'd0);
            if (!BR_N || !BGACK_N || !AS_N) chk("busy_in_cycle", 32'(BUSY), 32'd1);
            if (ACK) begin
                chk("ack_err", 32'(ERR), 32'(m_exp_err));
                chk("ack_rdata", 32'(RDATA), 32'(m_rdata_next));
                m_rdata = m_rdata_next;
                m_acks++;
            end else begin
                chk("err_without_ack", 32'(ERR), 32'd0);
                if (!BUSY) chk("idle_rdata", 32'(RDATA), 32'(m_rdata));
            end
        end else begin
            as_run = 0;
        end
    end

    task automatic do_cycle(input logic rw, input logic [22:0] a, input logic u, input logic l,
                            input logic [15:0] wd, input logic [15:0] din, input int bg_delay,
                            input int as_busy, input int dt_delay, input bit no_dtack,
                            input bit do_reset);
        @(posedge CLK); #1;
        REQ = 1'b1; REQ_RW = rw; REQ_ADDR = a; REQ_UDS = u; REQ_LDS = l; REQ_WDATA = wd;
        m_rw = rw; m_addr = a; m_uds = u; m_lds = l; m_wdata = wd;
        m_exp_err = no_dtack;
        m_rdata_next = (rw && !no_dtack) ? din : m_rdata;
        @(posedge CLK); #1;
        // Scramble the request lines: the latched copy must be used
        REQ = 1'b0; REQ_RW = ~rw; REQ_ADDR = ~a; REQ_UDS = ~u; REQ_LDS = ~l; REQ_WDATA = ~wd;
        wait_for(0, 1'b0, 10, "br_n_low");
        for (int i = 0; i < bg_delay; i++) begin
            @(negedge CLK);
            chk("as_n_no_grant", 32'(AS_N), 32'd1);
            chk("busy_no_grant", 32'(BUSY), 32'd1);
        end
        BG_N = 1'b0;
        AS_IN_N = (as_busy > 0) ? 1'b0 : 1'b1;
        for (int i = 0; i < as_busy; i++) begin
            @(negedge CLK);
            chk("bgack_held_off", 32'(BGACK_N), 32'd1);
        end
        AS_IN_N = 1'b1;
        wait_for(3, 1'b1, 10, "bus_oe_high");
        chk("s_addr_as_n", 32'(AS_N), 32'd1);
        chk("s_addr_data_oe", 32'(DATA_OE), 32'(!rw));
        chk("s_addr_addr", 32'(ADDR), 32'(a));
        chk("s_addr_br_n", 32'(BR_N), 32'd1);
        if (!rw) chk("s_addr_data_out", 32'(DATA_OUT), 32'(wd));
        wait_for(1, 1'b0, 4, "as_n_low");
        if (do_reset) begin
            repeat (4) @(negedge CLK);
            m_rdata = 16'd0;
            RST = 1'b0;
            @(negedge CLK);
            chk("rst_as_n", 32'(AS_N), 32'd1);
            chk("rst_uds_n", 32'(UDS_N), 32'd1);
            chk("rst_lds_n", 32'(LDS_N), 32'd1);
            chk("rst_bgack_n", 32'(BGACK_N), 32'd1);
            chk("rst_br_n", 32'(BR_N), 32'd1);
            chk("rst_busy", 32'(BUSY), 32'd0);
            chk("rst_ack", 32'(ACK), 32'd0);
            chk("rst_bus_oe", 32'(BUS_OE), 32'd0);
            chk("rst_data_oe", 32'(DATA_OE), 32'd0);
            chk("rst_rw", 32'(RW), 32'd1);
            chk("rst_addr", 32'(ADDR), 32'd0);
            chk("rst_rdata", 32'(RDATA), 32'd0);
            BG_N = 1'b1;
            RST = 1'b1;
            repeat (4) @(negedge CLK);
            chk("rst_no_ack", 32'(m_acks), 32'(tx_count));
            return;
        end
        if (!no_dtack) begin
            repeat (dt_delay) @(posedge CLK);
            #1;
            DTACK_N = 1'b0;
            DATA_IN = din;
            wait_for(1, 1'b1, 12, "as_n_release");
            DTACK_N = 1'b1;
            DATA_IN = 16'hDEAD;
        end else begin
            wait_for(1, 1'b1, 40, "as_n_timeout_release");
        end
        BG_N = 1'b1;
        wait_for(2, 1'b1, 12, "ack");
        tx_count++;
        repeat (3) @(negedge CLK);
        chk("ack_count", 32'(m_acks), 32'(tx_count));
        chk("end_br_n", 32'(BR_N), 32'd1);
        chk("end_bgack_n", 32'(BGACK_N), 32'd1);
        chk("end_busy", 32'(BUSY), 32'd0);
        chk("end_bus_oe", 32'(BUS_OE), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("init_as_n", 32'(AS_N), 32'd1);
        chk("init_br_n", 32'(BR_N), 32'd1);
        chk("init_bgack_n", 32'(BGACK_N), 32'd1);
        chk("init_rw", 32'(RW), 32'd1);
        chk("init_busy", 32'(BUSY), 32'd0);
        chk("init_rdata", 32'(RDATA), 32'd0);
        chk("init_data_out", 32'(DATA_OUT), 32'd0);
        chk("init_err", 32'(ERR), 32'd0);
        RST = 1'b1;

        // Read, both enables, DTACK 3 cycles after AS falls: AS low 7 cycles
        do_cycle(1'b1, 23'h3C0010, 1'b1, 1'b1, 16'h0000, 16'hA55A, 0, 0, 3, 1'b0, 1'b0);
        chk("t1_as_len", 32'(last_as_len), 32'd7);
        chk("t1_rdata", 32'(RDATA), 32'h0000A55A);

        // Write, lower byte only
        do_cycle(1'b0, 23'h000100, 1'b0, 1'b1, 16'h12EF, 16'h0000, 0, 0, 1, 1'b0, 1'b0);
        chk("t2_rdata_kept", 32'(RDATA), 32'h0000A55A);

        // Grant withheld for 20 cycles
        do_cycle(1'b1, 23'h7FFFFF, 1'b1, 1'b0, 16'h0000, 16'h0F0F, 20, 0, 0, 1'b0, 1'b0);
        chk("t3_rdata", 32'(RDATA), 32'h00000F0F);

        // No enables, previous master still holding AS
        do_cycle(1'b1, 23'h000000, 1'b0, 1'b0, 16'h0000, 16'h1234, 0, 6, 2, 1'b0, 1'b0);
        chk("t4_rdata", 32'(RDATA), 32'h00001234);

`ifdef MACK_BUS_TIMEOUT_EN
        // No DTACK: strobe cycle plus 16 wait cycles, then bus error
        do_cycle(1'b1, 23'h2AAAAA, 1'b1, 1'b1, 16'h0000, 16'hBEEF, 0, 0, 0, 1'b1, 1'b0);
        chk("t5_as_len", 32'(last_as_len), 32'd17);
        chk("t5_rdata_kept", 32'(RDATA), 32'h00001234);
`endif

        // Reset while waiting for DTACK
        do_cycle(1'b0, 23'h155555, 1'b1, 1'b1, 16'h5A5A, 16'h0000, 0, 0, 0, 1'b1, 1'b1);

        do_cycle(1'b1, 23'h000ABC, 1'b1, 1'b1, 16'h0000, 16'hC3C3, 0, 0, 2, 1'b0, 1'b0);
        chk("t7_rdata", 32'(RDATA), 32'h0000C3C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
